// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain arbiter slice.
// Holds the default sizing parameters and the debug state encoding.
package fifo_pkg;

    localparam int N_REQ_DEF        = 4;
    localparam int DATA_WIDTH_DEF   = 8;
    localparam int SEL_WIDTH_DEF    = 2;
    localparam int MAX_PRIO_RUN_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arbState_t;

endpackage

// File: rtl/fifo_drain_arbiter_rr_picker.sv
// rr_picker: combinational cyclic find-first.
// Scans req starting at index ptr, wrapping N_REQ-1 -> 0, and returns the
// first set position.
//   req   in  N_REQ      request vector
//   ptr   in  SEL_WIDTH  scan start index
//   idx   out SEL_WIDTH  index of first request at or after ptr
//   found out 1          any request set
module rr_picker #(
    parameter int N_REQ     = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [N_REQ-1:0]     req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] idx,
    output logic                 found
);

    int j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = SEL_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain of N_REQ fifo_cond instances into a
// single valid/ready stream. almostFull FIFOs win, but only MAX_PRIO_RUN times
// in a row before a plain round-robin grant is taken.
//   CLK, RST        clock, synchronous active-high reset
//   ENB             enable for new reads (in-flight data still drains)
//   fifoEmpty       per-FIFO outEmpty
//   fifoAlmostFull  per-FIFO almostFull
//   fifoData        per-FIFO outputData, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifoRead        one-hot sRead pulse
//   outReady        downstream accept
//   outValid        outData/outSel valid
//   outData         drained word
//   outSel          source FIFO of outData
module fifo_drain_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SEL_WIDTH    = SEL_WIDTH_DEF,
    parameter int MAX_PRIO_RUN = MAX_PRIO_RUN_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ENB,
    input  logic [N_REQ-1:0]            fifoEmpty,
    input  logic [N_REQ-1:0]            fifoAlmostFull,
    input  logic [N_REQ*DATA_WIDTH-1:0] fifoData,
    output logic [N_REQ-1:0]            fifoRead,
    input  logic                        outReady,
    output logic                        outValid,
    output logic [DATA_WIDTH-1:0]       outData,
    output logic [SEL_WIDTH-1:0]        outSel
);

    localparam int PRW = $clog2(MAX_PRIO_RUN + 1);

    // registered state
    logic                 pending;
    logic [SEL_WIDTH-1:0] pendSel;
    logic [SEL_WIDTH-1:0] rrPtr;
    logic [SEL_WIDTH-1:0] lastRead;
    logic                 lastReadVld;
    logic [PRW-1:0]       prioRun;
    arbState_t            state, stateNxt;

    // combinational
    logic [DATA_WIDTH-1:0] dataArr [N_REQ];
    logic [N_REQ-1:0]      elig;
    logic [N_REQ-1:0]      prioReq;
    logic [SEL_WIDTH-1:0]  prioIdx, plainIdx, grant, rrNext;
    logic                  prioFound, plainFound, usePrio;
    logic                  pendingMoves, issue;
    logic                  nxtPending, nxtOutValid;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            dataArr[i] = fifoData[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A FIFO read last cycle still shows its old outEmpty, so skip it for
    // one cycle to avoid reading past its last word.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = !fifoEmpty[i] && !(lastReadVld && (lastRead == SEL_WIDTH'(i)));
        end
    end

    assign prioReq = elig & fifoAlmostFull;

    rr_picker #(.N_REQ(N_REQ), .SEL_WIDTH(SEL_WIDTH)) uPrioPick (
        .req   (prioReq),
        .ptr   (rrPtr),
        .idx   (prioIdx),
        .found (prioFound)
    );

    rr_picker #(.N_REQ(N_REQ), .SEL_WIDTH(SEL_WIDTH)) uPlainPick (
        .req   (elig),
        .ptr   (rrPtr),
        .idx   (plainIdx),
        .found (plainFound)
    );

    assign usePrio = prioFound && (prioRun < PRW'(MAX_PRIO_RUN));
    assign grant   = usePrio ? prioIdx : plainIdx;
    assign rrNext  = (grant == SEL_WIDTH'(N_REQ - 1)) ? '0 : grant + 1'b1;

    // The pending slot may refill in the same cycle it empties, which is what
    // sustains one word per cycle.
    assign pendingMoves = pending && (!outValid || outReady);
    assign issue        = !RST && ENB && plainFound && (!pending || pendingMoves);
    assign fifoRead     = issue ? (N_REQ'(1) << grant) : '0;

    assign nxtPending  = issue || (pending && !pendingMoves);
    assign nxtOutValid = pendingMoves || (outValid && !outReady);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending     <= 1'b0;
            pendSel     <= '0;
            rrPtr       <= '0;
            lastRead    <= '0;
            lastReadVld <= 1'b0;
            prioRun     <= '0;
            outValid    <= 1'b0;
            outData     <= '0;
            outSel      <= '0;
        end else begin
            lastReadVld <= issue;
            lastRead    <= grant;

            if (issue) begin
                pending <= 1'b1;
                pendSel <= grant;
                rrPtr   <= rrNext;
                prioRun <= usePrio ? prioRun + 1'b1 : '0;
            end else if (pendingMoves) begin
                pending <= 1'b0;
            end

            // fifo_cond outputData is registered, so the word for a read in
            // cycle t is sampled here in cycle t+1.
            if (pendingMoves) begin
                outValid <= 1'b1;
                outData  <= dataArr[pendSel];
                outSel   <= pendSel;
            end else if (outValid && outReady) begin
                outValid <= 1'b0;
            end
        end
    end

    // Debug-only state tracking of the output pipeline.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (issue) stateNxt = ACTIVE;
            end
            ACTIVE: begin
                if (outValid && !outReady && pending) stateNxt = STALL;
                else if (!nxtPending && !nxtOutValid)  stateNxt = IDLE;
            end
            STALL: begin
                if (outReady) stateNxt = ACTIVE;
            end
            default: stateNxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
module tb_fifo_drain_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENB = 1'b1;
    logic [3:0]  fifoEmpty;
    logic [3:0]  fifoAlmostFull = '0;
    logic [31:0] fifoData;
    logic [3:0]  fifoRead;
    logic        outReady = 1'b1;
    logic        outValid;
    logic [7:0]  outData;
    logic [1:0]  outSel;

    int nCmp  = 0;
    int nFail = 0;

    fifo_drain_arbiter dut (
        .CLK            (CLK),
        .RST            (RST),
        .ENB            (ENB),
        .fifoEmpty      (fifoEmpty),
        .fifoAlmostFull (fifoAlmostFull),
        .fifoData       (fifoData),
        .fifoRead       (fifoRead),
        .outReady       (outReady),
        .outValid       (outValid),
        .outData        (outData),
        .outSel         (outSel)
    );

    always #5 CLK = ~CLK;

    // Behavioural fifo_cond stand-ins: registered outputData, count-based empty.
    logic       fifoClr = 1'b0;
    logic       pushEn  = 1'b0;
    int         pushIdx = 0;
    logic [7:0] pushVal = '0;
    logic [7:0] mem  [4][8];
    logic [2:0] hd   [4];
    logic [2:0] tl   [4];
    logic [3:0] cnt  [4];
    logic [7:0] dReg [4];
    logic       emptyReadSeen = 1'b0;

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (fifoClr) begin
                hd[i] <= '0; tl[i] <= '0; cnt[i] <= '0; dReg[i] <= '0;
            end else begin
                if (pushEn && pushIdx == i) begin
                    mem[i][tl[i]] <= pushVal;
                    tl[i] <= tl[i] + 3'd1;
                end
                if (fifoRead[i] && cnt[i] != 0) begin
                    dReg[i] <= mem[i][hd[i]];
                    hd[i] <= hd[i] + 3'd1;
                end
                if (fifoRead[i] && cnt[i] == 0) emptyReadSeen <= 1'b1;
                cnt[i] <= cnt[i] + ((pushEn && pushIdx == i) ? 4'd1 : 4'd0)
                                 - ((fifoRead[i] && cnt[i] != 0) ? 4'd1 : 4'd0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) fifoEmpty[i] = (cnt[i] == 0);
    end
    assign fifoData = {dReg[3], dReg[2], dReg[1], dReg[0]};

    task automatic prep(input logic [3:0] af);
        RST = 1'b1; ENB = 1'b1; outReady = 1'b1; fifoAlmostFull = af;
        fifoClr = 1'b1;
        @(posedge CLK); #1;
        fifoClr = 1'b0;
    endtask

    task automatic push(input int idx, input logic [7:0] v);
        pushEn = 1'b1; pushIdx = idx; pushVal = v;
        @(posedge CLK); #1;
        pushEn = 1'b0;
    endtask

    task automatic test_reset();
        prep(4'b0000);
        push(0, 8'hEE);
        @(negedge CLK);
        nCmp++; if (fifoRead !== 4'b0000) begin nFail++; $display("FAIL rst_read got %b exp 0000", fifoRead); end
        nCmp++; if (outValid !== 1'b0) begin nFail++; $display("FAIL rst_valid got %b exp 0", outValid); end
        nCmp++; if (outData !== 8'h00) begin nFail++; $display("FAIL rst_data got %h exp 00", outData); end
        nCmp++; if (outSel !== 2'd0) begin nFail++; $display("FAIL rst_sel got %0d exp 0", outSel); end
    endtask

    task automatic test_single_fifo();
        logic [3:0] rd [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
        logic       v  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        logic [7:0] d  [8] = '{0, 0, 8'hA1, 0, 8'hA2, 0, 8'hA3, 0};
        prep(4'b0000);
        push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            nCmp++; if (fifoRead !== rd[c]) begin nFail++; $display("FAIL single_read c%0d got %b exp %b", c, fifoRead, rd[c]); end
            nCmp++; if (outValid !== v[c]) begin nFail++; $display("FAIL single_valid c%0d got %b exp %b", c, outValid, v[c]); end
            if (v[c]) begin
                nCmp++; if ({outData, outSel} !== {d[c], 2'd0}) begin nFail++; $display("FAIL single_data c%0d got %h/%0d exp %h/0", c, outData, outSel, d[c]); end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rd [11] = '{1, 2, 4, 8, 1, 2, 4, 8, 0, 0, 0};
        logic       v  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] d  [11] = '{0, 0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41, 0};
        logic [1:0] s  [11] = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 3, 0};
        prep(4'b0000);
        for (int i = 0; i < 4; i++) begin
            push(i, 8'((i + 1) * 16));
            push(i, 8'((i + 1) * 16 + 1));
        end
        RST = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(negedge CLK);
            nCmp++; if (fifoRead !== rd[c]) begin nFail++; $display("FAIL rr_read c%0d got %b exp %b", c, fifoRead, rd[c]); end
            nCmp++; if (outValid !== v[c]) begin nFail++; $display("FAIL rr_valid c%0d got %b exp %b", c, outValid, v[c]); end
            if (v[c]) begin
                nCmp++; if ({outData, outSel} !== {d[c], s[c]}) begin nFail++; $display("FAIL rr_data c%0d got %h/%0d exp %h/%0d", c, outData, outSel, d[c], s[c]); end
            end
            @(posedge CLK); #1;
        end
    endtask

    // FIFO0 and FIFO2 almostFull: third priority grant in a row forces the
    // plain pick of FIFO1 in cycle 3 instead of FIFO2.
    task automatic test_priority();
        logic [3:0] rd [9] = '{1, 4, 1, 2, 4, 8, 0, 0, 0};
        logic       v  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] d  [9] = '{0, 0, 8'h01, 8'h21, 8'h02, 8'h11, 8'h22, 8'h31, 0};
        logic [1:0] s  [9] = '{0, 0, 0, 2, 0, 1, 2, 3, 0};
        prep(4'b0101);
        push(0, 8'h01); push(0, 8'h02); push(1, 8'h11);
        push(2, 8'h21); push(2, 8'h22); push(3, 8'h31);
        RST = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            nCmp++; if (fifoRead !== rd[c]) begin nFail++; $display("FAIL prio_read c%0d got %b exp %b", c, fifoRead, rd[c]); end
            nCmp++; if (outValid !== v[c]) begin nFail++; $display("FAIL prio_valid c%0d got %b exp %b", c, outValid, v[c]); end
            if (v[c]) begin
                nCmp++; if ({outData, outSel} !== {d[c], s[c]}) begin nFail++; $display("FAIL prio_data c%0d got %h/%0d exp %h/%0d", c, outData, outSel, d[c], s[c]); end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_backpressure();
        logic       rdy [14] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [3:0] rd  [14] = '{1, 2, 1, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0};
        logic       v   [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] d   [14] = '{0, 0, 8'h50, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h51, 8'h61, 8'h52, 8'h62, 0};
        logic [1:0] s   [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0};
        prep(4'b0000);
        push(0, 8'h50); push(0, 8'h51); push(0, 8'h52);
        push(1, 8'h60); push(1, 8'h61); push(1, 8'h62);
        RST = 1'b0;
        for (int c = 0; c < 14; c++) begin
            outReady = rdy[c];
            @(negedge CLK);
            nCmp++; if (fifoRead !== rd[c]) begin nFail++; $display("FAIL bp_read c%0d got %b exp %b", c, fifoRead, rd[c]); end
            nCmp++; if (outValid !== v[c]) begin nFail++; $display("FAIL bp_valid c%0d got %b exp %b", c, outValid, v[c]); end
            if (v[c]) begin
                nCmp++; if ({outData, outSel} !== {d[c], s[c]}) begin nFail++; $display("FAIL bp_data c%0d got %h/%0d exp %h/%0d", c, outData, outSel, d[c], s[c]); end
            end
            @(posedge CLK); #1;
        end
        outReady = 1'b1;
    endtask

    task automatic test_enable();
        logic       en [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [3:0] rd [12] = '{1, 2, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0};
        logic       v  [12] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0};
        logic [7:0] d  [12] = '{0, 0, 8'h70, 8'h80, 0, 0, 0, 0, 8'h90, 8'h71, 8'h81, 0};
        logic [1:0] s  [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 1, 0};
        prep(4'b0000);
        push(0, 8'h70); push(0, 8'h71); push(1, 8'h80); push(1, 8'h81); push(2, 8'h90);
        RST = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ENB = en[c];
            @(negedge CLK);
            nCmp++; if (fifoRead !== rd[c]) begin nFail++; $display("FAIL enb_read c%0d got %b exp %b", c, fifoRead, rd[c]); end
            nCmp++; if (outValid !== v[c]) begin nFail++; $display("FAIL enb_valid c%0d got %b exp %b", c, outValid, v[c]); end
            if (v[c]) begin
                nCmp++; if ({outData, outSel} !== {d[c], s[c]}) begin nFail++; $display("FAIL enb_data c%0d got %h/%0d exp %h/%0d", c, outData, outSel, d[c], s[c]); end
            end
            @(posedge CLK); #1;
        end
        ENB = 1'b1;
    endtask

    // Reset in cycle 2 with FIFO1's word pending: rrPtr back to 0 means FIFO0
    // (not FIFO2) is read next, and C1 never appears.
    task automatic test_reset_midstream();
        logic       rs  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        logic       rdy [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        logic [3:0] rd  [8] = '{1, 2, 0, 1, 2, 4, 0, 0};
        logic       v   [8] = '{0, 0, 1, 0, 0, 1, 1, 1};
        logic [7:0] d   [8] = '{0, 0, 8'hB1, 0, 0, 8'hB2, 8'hC2, 8'hD1};
        logic [1:0] s   [8] = '{0, 0, 0, 0, 0, 0, 1, 2};
        prep(4'b0000);
        push(0, 8'hB1); push(0, 8'hB2); push(1, 8'hC1); push(1, 8'hC2); push(2, 8'hD1);
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            RST = rs[c]; outReady = rdy[c];
            @(negedge CLK);
            nCmp++; if (fifoRead !== rd[c]) begin nFail++; $display("FAIL rstmid_read c%0d got %b exp %b", c, fifoRead, rd[c]); end
            nCmp++; if (outValid !== v[c]) begin nFail++; $display("FAIL rstmid_valid c%0d got %b exp %b", c, outValid, v[c]); end
            if (v[c] || c == 3) begin
                nCmp++; if ({outData, outSel} !== {d[c], s[c]}) begin nFail++; $display("FAIL rstmid_data c%0d got %h/%0d exp %h/%0d", c, outData, outSel, d[c], s[c]); end
            end
            @(posedge CLK); #1;
        end
        outReady = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_fifo();
        test_round_robin();
        test_priority();
        test_backpressure();
        test_enable();
        test_reset_midstream();
        nCmp++; if (emptyReadSeen !== 1'b0) begin nFail++; $display("FAIL empty_read got %b exp 0", emptyReadSeen); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
Round-robin scheduler that drains N_REQ fifo_cond instances into one shared downstream stream. It watches each FIFO's outEmpty/almostFull flags and issues single-cycle sRead pulses to at most one FIFO per cycle. It then captures that FIFO's registered outputData and presents it downstream with a valid/ready handshake. FIFOs flagged almostFull get priority, bounded by an anti-starvation counter.

Parameters:
N_REQ, 4, number of FIFOs arbitrated (2..8)
DATA_WIDTH, 8, FIFO data width
SEL_WIDTH, 2, width of FIFO index; equals ceil(log2(N_REQ))
MAX_PRIO_RUN, 3, max consecutive priority (almostFull) grants before one plain round-robin grant is forced

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
ENB  in  1  enable; when low, no new reads issued, pipeline holds
fifoEmpty  in  N_REQ  outEmpty flag of each FIFO
fifoAlmostFull  in  N_REQ  almostFull flag of each FIFO
fifoData  in  N_REQ*DATA_WIDTH  outputData of each FIFO; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
fifoRead  out  N_REQ  one-hot sRead pulse to each FIFO
outReady  in  1  downstream accepts outData this cycle
outValid  out  1  outData/outSel valid
outData  out  DATA_WIDTH  drained word
outSel  out  SEL_WIDTH  index of source FIFO for outData

Behaviour:
- Reset (RST=1 at edge): fifoRead=0, outValid=0, outData=0, outSel=0, pending=0, rrPtr=0, lastRead=none, prioRun=0, state=IDLE. Takes priority over ENB.
- fifoRead is combinational from registered state plus inputs. It is at most one-hot and never asserted during reset or when ENB=0.
- Eligibility of FIFO i in cycle t: fifoEmpty[i]=0 AND i was not read in cycle t-1. The flag-settle rule applies because fifo_cond updates outEmpty one cycle after the read.
- Issue condition in cycle t: ENB=1 AND some FIFO eligible AND (pending=0 OR pendingMoves). pendingMoves = pending AND (outValid=0 OR outReady=1).
- Selection:
  - If any eligible FIFO has almostFull and prioRun<MAX_PRIO_RUN, grant the first such FIFO at or after rrPtr (cyclic), then prioRun++.
  - Otherwise grant the first eligible FIFO at or after rrPtr, then prioRun=0.
  - After any grant g: rrPtr=(g+1) mod N_REQ, wrapping N_REQ-1 -> 0.
- Pipeline:
  - Grant in cycle t sets pending=1, pendSel=g at end of t.
  - fifoData[pendSel] is valid from t+1 and stays stable until that FIFO is read again.
  - When pendingMoves: outData<=fifoData[pendSel], outSel<=pendSel, outValid<=1.
  - Minimum latency is read pulse -> outValid = 2 cycles.
- Handshake:
  - Transfer happens on an edge with outValid=1 AND outReady=1.
  - outValid=1 AND outReady=0: outData/outSel hold, pending holds, no new reads.
  - Sustained throughput is 1 word/cycle when at least two FIFOs are non-empty. With a single non-empty FIFO it is 1 word/2 cycles (flag-settle rule).
  - outValid drops to 0 after a transfer only if nothing is moving from pending.
- State machine (registered, for debug/visibility):
  - IDLE (nothing pending or valid) -> ACTIVE on a grant.
  - ACTIVE -> STALL when outValid AND NOT outReady AND pending.
  - STALL -> ACTIVE when outReady.
  - ACTIVE -> IDLE when pipeline empties.
- ENB=0 mid-operation: no reads issued. A pending word may still move to the output and transfers still complete, so no data is lost or duplicated.
- Never reads a FIFO whose fifoEmpty=1, so fifo_cond errorEmpty is never triggered by this block.
- All FIFOs empty: fifoRead=0, state returns to IDLE after the final transfer.

Decomposition:
- Shared package (fifo_pkg): N_REQ, DATA_WIDTH, SEL_WIDTH defaults and the state encoding IDLE=2'd0, ACTIVE=2'd1, STALL=2'd2.
- One sub-module, rr_picker: combinational cyclic find-first over an N_REQ request vector starting at rrPtr. Outputs grant index and found flag. It is instantiated twice: once for the priority vector, once for the plain vector.

Test Plan:
- FIFO0 holds 3 words (0xA1,0xA2,0xA3), others empty, outReady=1 -> reads to FIFO0 in cycles 0,2,4. outValid in cycles 2,4,6 with data A1,A2,A3, outSel=0.
- FIFO0..3 each hold 2 words, outReady=1, no almostFull -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles, 8 words out back-to-back.
- FIFO2 almostFull, FIFO0/1 non-empty, MAX_PRIO_RUN=3 -> grants 2,x,2,x,2 (with flag-settle gaps filled by 0/1). After 3 priority grants, one plain RR grant is forced before FIFO2 wins again.
- Stream active, then outReady=0 for 5 cycles -> outData/outSel constant, exactly one pending, no fifoRead pulses. On outReady=1 the stream resumes with no loss or duplication.
- ENB low for 4 cycles mid-stream -> no fifoRead; the in-flight word still emerges; resumes in RR order from the saved rrPtr.
- RST asserted while pending=1 and outValid=1 -> next cycle all outputs 0, rrPtr=0, and the word is not emitted.
